case_3_mul_pipe_acc: RTL and testbench



---
 rtl/case_3_mul_pipe_acc.sv | 151 +++++++++++++++
 tb/tb_case_3_mul_pipe_acc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/case_3_mul_pipe_acc.sv
// Pipelined multiplier with valid/ready flow control and optional multiply-accumulate.
// The accumulate path is compiled in only when CASE_3_MUL_PIPE_ACC_EN is defined.
module case_3_mul_pipe_acc #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 8,
    parameter int din1_WIDTH = 7,
    parameter int dout_WIDTH = 16,
    parameter int SIGNED0    = 1,
    parameter int SIGNED1    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  acc_mode,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout
);

    localparam int EXT_W = din0_WIDTH + din1_WIDTH + 1;
    localparam int MUL_W = (EXT_W > dout_WIDTH) ? EXT_W : dout_WIDTH;
    localparam int unused_id = ID;

    // Operands are extended to the wider of the full-product and result widths,
    // so the low dout_WIDTH bits come out truncated or extended as needed.
    function automatic logic [dout_WIDTH-1:0] mul(input logic [din0_WIDTH-1:0] a,
                                                  input logic [din1_WIDTH-1:0] b);
        logic [MUL_W-1:0] ax;
        logic [MUL_W-1:0] bx;
        logic [MUL_W-1:0] p;
        ax = (SIGNED0 != 0) ? {{(MUL_W-din0_WIDTH){a[din0_WIDTH-1]}}, a}
                            : {{(MUL_W-din0_WIDTH){1'b0}}, a};
        bx = (SIGNED1 != 0) ? {{(MUL_W-din1_WIDTH){b[din1_WIDTH-1]}}, b}
                            : {{(MUL_W-din1_WIDTH){1'b0}}, b};
        p  = ax * bx;
        return p[dout_WIDTH-1:0];
    endfunction

    logic                  advance;
    logic                  fin_vld;
    logic                  fin_acc;
    logic                  fin_last;
    logic [dout_WIDTH-1:0] fin_prod;

    assign advance  = ce & (~out_valid | out_ready);
    assign in_ready = advance & ~reset;

    generate
        if (NUM_STAGE == 1) begin : g_s1
            // Single stage: the product of the live inputs is captured by the output register.
            assign fin_vld  = in_valid;
            assign fin_acc  = acc_mode;
            assign fin_last = in_last;
            assign fin_prod = mul(din0, din1);
        end else begin : g_sn
            logic [NUM_STAGE-2:0]  vld_pipe;
            logic [NUM_STAGE-2:0]  acc_pipe;
            logic [NUM_STAGE-2:0]  last_pipe;
            logic [din0_WIDTH-1:0] op0_q;
            logic [din1_WIDTH-1:0] op1_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_pipe <= '0;
                end else if (advance) begin
                    vld_pipe[0]  <= in_valid;
                    acc_pipe[0]  <= acc_mode;
                    last_pipe[0] <= in_last;
                    op0_q        <= din0;
                    op1_q        <= din1;
                    for (int i = 1; i < NUM_STAGE - 1; i++) begin
                        vld_pipe[i]  <= vld_pipe[i-1];
                        acc_pipe[i]  <= acc_pipe[i-1];
                        last_pipe[i] <= last_pipe[i-1];
                    end
                end
            end

            assign fin_vld  = vld_pipe[NUM_STAGE-2];
            assign fin_acc  = acc_pipe[NUM_STAGE-2];
            assign fin_last = last_pipe[NUM_STAGE-2];

            if (NUM_STAGE == 2) begin : g_p0
                assign fin_prod = mul(op0_q, op1_q);
            end else begin : g_pn
                // Product registers between the operand and output stages exist for retiming.
                logic [NUM_STAGE-3:0][dout_WIDTH-1:0] prod_pipe;

                always_ff @(posedge clk) begin
                    if (advance && !reset) begin
                        prod_pipe[0] <= mul(op0_q, op1_q);
                        for (int i = 1; i < NUM_STAGE - 2; i++) begin
                            prod_pipe[i] <= prod_pipe[i-1];
                        end
                    end
                end

                assign fin_prod = prod_pipe[NUM_STAGE-3];
            end
        end
    endgenerate

`ifdef CASE_3_MUL_PIPE_ACC_EN
    logic [dout_WIDTH-1:0] acc;

    // Group beats fold into acc; the closing beat emits the total and clears acc.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            acc       <= '0;
        end else if (advance) begin
            out_valid <= fin_vld & (~fin_acc | fin_last);
            if (fin_vld) begin
                if (fin_acc) begin
                    if (fin_last) begin
                        dout <= acc + fin_prod;
                        acc  <= '0;
                    end else begin
                        acc <= acc + fin_prod;
                    end
                end else begin
                    dout <= fin_prod;
                end
            end
        end
    end
`else
    logic unused_ctl;
    assign unused_ctl = fin_acc ^ fin_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (advance) begin
            out_valid <= fin_vld;
            if (fin_vld) begin
                dout <= fin_prod;
            end
        end
    end
`endif

endmodule

// File: tb/tb_case_3_mul_pipe_acc.sv
// Directed bench: signed 3-stage instance plus an unsigned 2-stage instance.
// A beat offered in the cycle after edge t shows on dout after edge t+NUM_STAGE.
module tb_case_3_mul_pipe_acc;

    logic        clk = 1'b0;
    logic        reset, ce, in_valid, in_ready, acc_mode, in_last, out_valid, out_ready;
    logic [7:0]  din0;
    logic [6:0]  din1;
    logic [15:0] dout;

    logic        u_valid, u_in_ready, u_out_valid;
    logic [7:0]  u_din0;
    logic [6:0]  u_din1;
    logic [15:0] u_dout;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   got;
    int   idx;
    logic bp_on;
    logic took;
    logic seen;

    int bp_a[6] = '{3, -5, 7, -9, 11, 13};
    int bp_b[6] = '{2, 3, -4, 5, 6, -7};
    int bp_p[6] = '{6, -15, -28, -45, 66, -91};

    always #5 clk = ~clk;

    case_3_mul_pipe_acc #(.NUM_STAGE(3)) u_dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .acc_mode(acc_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
    );

    case_3_mul_pipe_acc #(.NUM_STAGE(2), .SIGNED0(0), .SIGNED1(0)) u_dut_u (
        .clk(clk), .reset(reset), .ce(1'b1), .in_valid(u_valid), .in_ready(u_in_ready),
        .din0(u_din0), .din1(u_din1), .acc_mode(1'b0), .in_last(1'b0),
        .out_valid(u_out_valid), .out_ready(1'b1), .dout(u_dout)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int a, input int b, input logic am, input logic lst);
        in_valid = 1'b1;
        din0     = 8'(a);
        din1     = 7'(b);
        acc_mode = am;
        in_last  = lst;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        acc_mode = 1'b0;
        in_last  = 1'b0;
    endtask

    // Scoreboard for the back-pressure stream: a result transfers at the next edge.
    always @(negedge clk) begin
        if (!bp_on) begin
            got = 0;
        end else if (out_valid && out_ready) begin
            if (got < 6) chk("bp_data", dout, 16'(bp_p[got]));
            else         chk("bp_dup", 16'(got), 16'd6);
            got = got + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; ce = 1'b1; out_ready = 1'b1; bp_on = 1'b0;
        din0 = '0; din1 = '0; idle();
        u_valid = 1'b0; u_din0 = '0; u_din1 = '0;
        idx = 0; seen = 1'b0;

        // Reset and idle
        tick();
        chk("rst_rdy", 16'(in_ready), 16'd0);
        chk("rst_vld", 16'(out_valid), 16'd0);
        chk("rst_dout", dout, 16'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("idle_vld", 16'(out_valid), 16'd0);
        chk("idle_dout", dout, 16'd0);
        chk("idle_rdy", 16'(in_ready), 16'd1);
        chk("u_rdy", 16'(u_in_ready), 16'd1);

        // Signed back-to-back stream, NUM_STAGE=3
        beat(-128, 63, 0, 0); tick();
        beat(127, -64, 0, 0); tick();
        chk("s_early", 16'(out_valid), 16'd0);
        beat(-1, -1, 0, 0);   tick();
        chk("s_lat_vld", 16'(out_valid), 16'd1);
        chk("s_p0", dout, 16'(-8064));
        beat(0, 5, 0, 0);     tick();
        chk("s_p1", dout, 16'(-8128));
        idle();               tick();
        chk("s_p2", dout, 16'd1);
        tick();
        chk("s_p3_vld", 16'(out_valid), 16'd1);
        chk("s_p3", dout, 16'd0);
        tick();
        chk("s_drain", 16'(out_valid), 16'd0);

        // Unsigned operands are not sign-interpreted
        u_valid = 1'b1; u_din0 = 8'hFF; u_din1 = 7'h7F; tick();
        chk("u_early", 16'(u_out_valid), 16'd0);
        u_din0 = 8'd200; u_din1 = 7'd100; tick();
        chk("u_p0", u_dout, 16'd32385);
        u_valid = 1'b0; tick();
        chk("u_p1", u_dout, 16'd20000);
        tick();
        chk("u_drain", 16'(u_out_valid), 16'd0);

        // ce=0 freezes the pipe; a held result stays visible
        beat(4, 4, 0, 0); tick();
        idle(); ce = 1'b0; tick();
        chk("ce_rdy", 16'(in_ready), 16'd0);
        tick(); tick();
        chk("ce_frozen", 16'(out_valid), 16'd0);
        ce = 1'b1; tick();
        chk("ce_mid", 16'(out_valid), 16'd0);
        tick();
        chk("ce_vld", 16'(out_valid), 16'd1);
        chk("ce_p", dout, 16'd16);
        ce = 1'b0; tick();
        chk("ce_hold_vld", 16'(out_valid), 16'd1);
        chk("ce_hold_p", dout, 16'd16);
        ce = 1'b1; tick();
        chk("ce_drain", 16'(out_valid), 16'd0);

        // Back-pressure: out_ready low for 4 cycles mid-stream
        bp_on = 1'b1; idx = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            out_ready = !(c >= 3 && c < 7);
            if (idx < 6) beat(bp_a[idx], bp_b[idx], 0, 0);
            else         idle();
            @(negedge clk);
            took = in_valid && in_ready;
            if (c == 5) begin
                chk("bp_rdy", 16'(in_ready), 16'd0);
                chk("bp_stall_vld", 16'(out_valid), 16'd1);
                chk("bp_stall_dout", dout, 16'd6);
            end
            @(posedge clk);
            #1;
            if (took) idx++;
        end
        idle(); out_ready = 1'b1;
        repeat (4) tick();
        chk("bp_cnt", 16'(got), 16'd6);
        chk("bp_sent", 16'(idx), 16'd6);
        bp_on = 1'b0;

`ifdef CASE_3_MUL_PIPE_ACC_EN
        // 3*4 + (-2)*5 + 7*7 = 51
        beat(3, 4, 1, 0);  tick();
        beat(-2, 5, 1, 0); tick();
        beat(7, 7, 1, 1);  tick();
        chk("acc_none0", 16'(out_valid), 16'd0);
        idle(); tick();
        chk("acc_none1", 16'(out_valid), 16'd0);
        tick();
        chk("acc_vld", 16'(out_valid), 16'd1);
        chk("acc_sum", dout, 16'd51);
        tick();
        chk("acc_single", 16'(out_valid), 16'd0);
        // Next group starts from zero: 1*1 + 2*2 = 5
        beat(1, 1, 1, 0); tick();
        beat(2, 2, 1, 1); tick();
        idle(); tick();
        chk("acc2_none", 16'(out_valid), 16'd0);
        tick();
        chk("acc2_sum", dout, 16'd5);
        // 30 * 127*63 = 240030, mod 65536 = 43422
        for (int i = 0; i < 30; i++) begin
            beat(127, 63, 1, (i == 29));
            tick();
        end
        idle(); tick(); tick();
        chk("acc_wrap_vld", 16'(out_valid), 16'd1);
        chk("acc_wrap", dout, 16'd43422);
        tick();
`else
        // Without the accumulator, acc_mode is ignored and every beat produces a result
        beat(3, 4, 1, 0); tick();
        idle(); tick(); tick();
        chk("plain_acc_vld", 16'(out_valid), 16'd1);
        chk("plain_acc_p", dout, 16'd12);
        tick();
`endif

        // Reset during a partial group with beats still in flight
        beat(5, 5, 1, 0); tick();
        beat(6, 6, 1, 0); tick();
        beat(7, 7, 1, 0); tick();
        idle(); reset = 1'b1; tick();
        chk("rm_vld", 16'(out_valid), 16'd0);
        chk("rm_rdy", 16'(in_ready), 16'd0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("rm_quiet", 16'(seen), 16'd0);
        beat(2, 3, 1, 1); tick();
        idle(); tick(); tick();
        chk("rm_vld2", 16'(out_valid), 16'd1);
        chk("rm_p", dout, 16'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
